// File: rtl/adder_entry_sequencer.sv
// Operand-entry and calculate sequencer for the 4-bit adder calculator.
// Registered digit codes and LED drive are derived from the next-state values, so they line up with state.
module adder_entry_sequencer #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [3:0]  DASH_CODE  = 4'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_a_p,
  input  logic       key_b_p,
  input  logic       key_cal_p,
  input  logic [3:0] sw_dig,
  input  logic [4:0] sum_in,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [3:0] dig_lt,
  output logic [3:0] dig_rt,
  output logic [2:0] led,
  output logic       busy,
  output logic       err
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {IDLE, A_SET, B_SET, CALC, RESULT} state_t;

  state_t     state, state_nx;
  logic [3:0] op_a_nx, op_b_nx;
  logic [3:0] cnt, cnt_nx;
  logic [4:0] result, result_nx;
  logic       err_nx;
  logic [4:0] disp_val;
  logic       dash;
  logic [4:0] rem;
  logic [3:0] lt_nx, rt_nx;
  logic [2:0] led_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      cnt    <= '0;
      dig_lt <= DASH_CODE;
      dig_rt <= DASH_CODE;
      led    <= 3'b111;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      op_a   <= op_a_nx;
      op_b   <= op_b_nx;
      result <= result_nx;
      cnt    <= cnt_nx;
      dig_lt <= lt_nx;
      dig_rt <= rt_nx;
      led    <= led_nx;
      busy   <= (state_nx == CALC);
      err    <= err_nx;
    end
  end

  // Key priority a > b > cal; only the winning key can raise err.
  always_comb begin
    state_nx  = state;
    op_a_nx   = op_a;
    op_b_nx   = op_b;
    result_nx = result;
    cnt_nx    = cnt;
    err_nx    = 1'b0;
    case (state)
      CALC: begin
        if (key_a_p || key_b_p || key_cal_p) err_nx = 1'b1;
        if (cnt == CNT_LAST) begin
          result_nx = sum_in;
          state_nx  = RESULT;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      default: begin
        if (key_a_p) begin
          op_a_nx  = sw_dig;
          state_nx = A_SET;
        end else if (key_b_p) begin
          if (state == A_SET || state == B_SET) begin
            op_b_nx  = sw_dig;
            state_nx = B_SET;
          end else begin
            err_nx = 1'b1;
          end
        end else if (key_cal_p) begin
          if (state == B_SET) begin
            cnt_nx   = '0;
            state_nx = CALC;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    disp_val = '0;
    dash     = 1'b0;
    led_nx   = 3'b111;
    case (state_nx)
      IDLE:    disp_val = {1'b0, sw_dig};
      A_SET:   begin disp_val = {1'b0, op_a_nx}; led_nx = 3'b110; end
      B_SET:   begin disp_val = {1'b0, op_b_nx}; led_nx = 3'b100; end
      RESULT:  begin disp_val = result_nx;       led_nx = 3'b011; end
      default: dash = 1'b1;
    endcase
  end

  // Compare/subtract binary->BCD; out-of-range sums saturate the units digit at 9.
  always_comb begin
    lt_nx = '0;
    rem   = disp_val;
    if (disp_val >= 5'd30) begin
      lt_nx = 4'd3;
      rem   = disp_val - 5'd30;
    end else if (disp_val >= 5'd20) begin
      lt_nx = 4'd2;
      rem   = disp_val - 5'd20;
    end else if (disp_val >= 5'd10) begin
      lt_nx = 4'd1;
      rem   = disp_val - 5'd10;
    end
    rt_nx = (rem > 5'd9) ? 4'd9 : rem[3:0];
    if (dash) begin
      lt_nx = DASH_CODE;
      rt_nx = DASH_CODE;
    end
  end

endmodule

// File: tb/tb_adder_entry_sequencer.sv
// Directed table-driven bench for adder_entry_sequencer plus hand sequences for reset and sweep cases.
module tb_adder_entry_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_a_p = 1'b0, key_b_p = 1'b0, key_cal_p = 1'b0;
  logic [3:0] sw_dig = '0;
  logic [4:0] sum_in = '0;
  logic [3:0] op_a, op_b, dig_lt, dig_rt;
  logic [2:0] led;
  logic       busy, err;

  int checks = 0;
  int failures = 0;

  localparam logic [3:0] D = 4'd10;

  adder_entry_sequencer #(.SETTLE_CYC(2), .DASH_CODE(4'd10)) dut (
    .clk(clk), .rst(rst), .key_a_p(key_a_p), .key_b_p(key_b_p), .key_cal_p(key_cal_p),
    .sw_dig(sw_dig), .sum_in(sum_in), .op_a(op_a), .op_b(op_b), .dig_lt(dig_lt),
    .dig_rt(dig_rt), .led(led), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       a, b, cal;
    logic [3:0] sw;
    logic [4:0] sum;
    logic [3:0] lt, rt;
    logic [2:0] led;
    logic       busy, err;
    logic [3:0] oa, ob;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic a, logic b, logic cal, int sw, int sum, int lt, int rt,
                              logic [2:0] l, logic bsy, logic e, int oa, int ob);
    vec_t v;
    v.a = a; v.b = b; v.cal = cal; v.sw = 4'(sw); v.sum = 5'(sum);
    v.lt = 4'(lt); v.rt = 4'(rt); v.led = l; v.busy = bsy; v.err = e;
    v.oa = 4'(oa); v.ob = 4'(ob);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int lt, input int rt, input int l,
                         input int bsy, input int e, input int oa, input int ob);
    chk({tag, " dig_lt"}, int'(dig_lt), lt);
    chk({tag, " dig_rt"}, int'(dig_rt), rt);
    chk({tag, " led"},    int'(led),    l);
    chk({tag, " busy"},   int'(busy),   bsy);
    chk({tag, " err"},    int'(err),    e);
    chk({tag, " op_a"},   int'(op_a),   oa);
    chk({tag, " op_b"},   int'(op_b),   ob);
  endtask

  task automatic step(input logic a, input logic b, input logic cal, input int sw, input int sum);
    @(negedge clk);
    key_a_p = a; key_b_p = b; key_cal_p = cal;
    sw_dig = 4'(sw); sum_in = 5'(sum);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             a  b  c  sw sum lt rt led     bsy err oa  ob
    vecs.push_back(mk(1, 0, 0,  9,  0, 0, 9, 3'b110, 0, 0,  9,  0));
    vecs.push_back(mk(0, 1, 0,  7,  0, 0, 7, 3'b100, 0, 0,  9,  7));
    vecs.push_back(mk(0, 0, 1,  7,  0, D, D, 3'b111, 1, 0,  9,  7));
    vecs.push_back(mk(0, 0, 0,  7, 16, D, D, 3'b111, 1, 0,  9,  7));
    vecs.push_back(mk(0, 0, 0,  7, 16, 1, 6, 3'b011, 0, 0,  9,  7));
    vecs.push_back(mk(0, 1, 0,  2, 16, 1, 6, 3'b011, 0, 1,  9,  7));
    vecs.push_back(mk(0, 0, 0,  2, 16, 1, 6, 3'b011, 0, 0,  9,  7));
    vecs.push_back(mk(1, 0, 0, 15,  0, 1, 5, 3'b110, 0, 0, 15,  7));
    vecs.push_back(mk(0, 1, 0, 15,  0, 1, 5, 3'b100, 0, 0, 15, 15));
    vecs.push_back(mk(0, 0, 1, 15,  0, D, D, 3'b111, 1, 0, 15, 15));
    vecs.push_back(mk(0, 0, 0, 15, 30, D, D, 3'b111, 1, 0, 15, 15));
    vecs.push_back(mk(0, 0, 0, 15, 30, 3, 0, 3'b011, 0, 0, 15, 15));
    vecs.push_back(mk(0, 0, 0,  1,  5, 3, 0, 3'b011, 0, 0, 15, 15));
    vecs.push_back(mk(1, 0, 0,  4,  0, 0, 4, 3'b110, 0, 0,  4, 15));
    vecs.push_back(mk(0, 1, 0,  2,  0, 0, 2, 3'b100, 0, 0,  4,  2));
    vecs.push_back(mk(0, 0, 1,  2,  0, D, D, 3'b111, 1, 0,  4,  2));
    vecs.push_back(mk(1, 0, 0,  9,  6, D, D, 3'b111, 1, 1,  4,  2));
    vecs.push_back(mk(0, 0, 0,  9,  6, 0, 6, 3'b011, 0, 0,  4,  2));
    vecs.push_back(mk(1, 0, 0,  3,  0, 0, 3, 3'b110, 0, 0,  3,  2));
    vecs.push_back(mk(0, 1, 0,  8,  0, 0, 8, 3'b100, 0, 0,  3,  8));
    vecs.push_back(mk(1, 0, 1,  4,  0, 0, 4, 3'b110, 0, 0,  4,  8));
    vecs.push_back(mk(0, 0, 1,  4,  0, 0, 4, 3'b110, 0, 1,  4,  8));
    vecs.push_back(mk(0, 1, 0,  5,  0, 0, 5, 3'b100, 0, 0,  4,  5));
    vecs.push_back(mk(0, 0, 1,  5,  0, D, D, 3'b111, 1, 0,  4,  5));
    vecs.push_back(mk(0, 0, 0,  5, 31, D, D, 3'b111, 1, 0,  4,  5));
    vecs.push_back(mk(0, 0, 0,  5, 31, 3, 1, 3'b011, 0, 0,  4,  5));
    vecs.push_back(mk(1, 0, 0, 12,  0, 1, 2, 3'b110, 0, 0, 12,  5));
    vecs.push_back(mk(0, 1, 0, 13,  0, 1, 3, 3'b100, 0, 0, 12, 13));
    vecs.push_back(mk(0, 0, 1, 13,  0, D, D, 3'b111, 1, 0, 12, 13));
    vecs.push_back(mk(0, 0, 0, 13, 25, D, D, 3'b111, 1, 0, 12, 13));
    vecs.push_back(mk(0, 0, 0, 13, 25, 2, 5, 3'b011, 0, 0, 12, 13));

    #12;
    chk_all("reset", D, D, 3'b111, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].a, vecs[i].b, vecs[i].cal, int'(vecs[i].sw), int'(vecs[i].sum));
      chk_all($sformatf("vec%0d", i), int'(vecs[i].lt), int'(vecs[i].rt), int'(vecs[i].led),
              int'(vecs[i].busy), int'(vecs[i].err), int'(vecs[i].oa), int'(vecs[i].ob));
    end

    // Back to IDLE via reset, then key_cal in IDLE and a live switch sweep.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("rst2", D, D, 3'b111, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 1, 5, 0);
    chk_all("idle_cal", 0, 5, 3'b111, 0, 1, 0, 0);
    step(0, 0, 0, 5, 0);
    chk_all("idle_cal_clr", 0, 5, 3'b111, 0, 0, 0, 0);
    for (int s = 0; s < 16; s++) begin
      step(0, 0, 0, s, 0);
      chk($sformatf("sweep%0d lt", s), int'(dig_lt), s / 10);
      chk($sformatf("sweep%0d rt", s), int'(dig_rt), s % 10);
    end

    // Reset asserted mid-CALC aborts without capturing sum_in.
    step(1, 0, 0, 6, 0);
    step(0, 1, 0, 3, 0);
    step(0, 0, 1, 3, 20);
    chk("midcalc busy", int'(busy), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("midcalc_rst", D, D, 3'b111, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 6, 20);
      chk_all($sformatf("post_rst%0d", k), 0, 6, 3'b111, 0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
